pixel_window_capture: RTL
=========================

Name: pixel_window_capture

Overview:
- Parametrised successor of the camera capture front end: samples the raw sensor stream (data, FVAL, LVAL) on the pixel clock and emits a cropped, decimated pixel stream with window-relative X/Y coordinates.
- Adds a configurable crop window, power-of-two decimation, single-shot/continuous modes, frame-aligned start/stop and SOF/EOF markers.
- Sits between the sensor input registers and the Bayer-to-RGB/graphics path; its outputs feed the frame-buffer write side.

Parameters:
DATA_W, 12, pixel data width
X_W, 16, width of raw and window X coordinates
Y_W, 16, width of raw and window Y coordinates
FRAME_W, 32, width of the frame counter
DEC_W, 2, width of the decimation exponent (factor = 2^i_decim, max 2^(2^DEC_W-1))

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
i_data  in  DATA_W  raw sensor pixel
i_fval  in  1  frame valid
i_lval  in  1  line valid
i_start  in  1  one-cycle pulse: arm capture
i_stop  in  1  one-cycle pulse: request stop after the current frame
i_single  in  1  1 = capture one frame then return to idle; sampled with i_start
i_win_x0  in  X_W  window origin X (raw pixels)
i_win_y0  in  Y_W  window origin Y (raw lines)
i_win_w  in  X_W  window width (raw pixels)
i_win_h  in  Y_W  window height (raw lines)
i_decim  in  DEC_W  decimation exponent d
o_data  out  DATA_W  windowed pixel
o_dval  out  1  o_data/o_x/o_y valid
o_x  out  X_W  window-relative decimated X
o_y  out  Y_W  window-relative decimated Y
o_sof  out  1  high with the first o_dval of a frame
o_eof  out  1  one-cycle pulse at end of a captured frame
o_frame_cnt  out  FRAME_W  completed captured frames
o_busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0, stop latch 0. Reset is asynchronous and takes effect mid-frame with no EOF pulse.
- Stage 1 registers i_data/i_fval/i_lval. Stage 2 registers all outputs. Pixel sampled at cycle n appears at n+2.
- States:
  - IDLE: i_start -> WAIT_SOF; latch i_single.
  - WAIT_SOF: on a registered FVAL rising edge -> ACTIVE; sample window and decimation configuration into shadow registers. A start issued mid-frame therefore waits for the next frame.
  - ACTIVE: on the registered FVAL falling edge, pulse o_eof, increment o_frame_cnt (wraps modulo 2^FRAME_W), then go to IDLE if single mode or the stop latch is set, otherwise to WAIT_SOF.
- Stop handling: i_stop in WAIT_SOF -> IDLE immediately. i_stop in ACTIVE sets the stop latch and the frame completes. i_start and i_stop in the same cycle: stop wins. i_start while busy is ignored.
- Raw counters, active only in ACTIVE:
  - rx increments on each registered LVAL-high cycle and clears when LVAL is low.
  - ry increments on each registered LVAL falling edge and clears at SOF.
  - Both saturate at all-ones.
- Emit condition: LVAL high, x0 <= rx < x0+w, y0 <= ry < y0+h, low d bits of (rx-x0) are 0 and low d bits of (ry-y0) are 0.
  - o_x = (rx-x0)>>d, o_y = (ry-y0)>>d.
  - x0+w and y0+h are computed 1 bit wider; no wrap.
- Boundary cases: w=0 or h=0 -> no pixels, but EOF and the frame count still occur. A window extending past the sensor frame is truncated silently.
- o_sof is asserted with the first emitted pixel of the frame only. If no pixel is emitted, o_sof never pulses.
- Configuration input changes during ACTIVE have no effect until the next SOF.

Test Plan:
- Full window: 8x4 frame, x0=y0=0, w=8, h=4, d=0, continuous -> 32 o_dval; o_x 0..7, o_y 0..3; o_sof on first pixel; o_eof once; o_frame_cnt=1; first o_dval 2 cycles after first LVAL pixel.
- Crop: 8x4 frame, x0=2, y0=1, w=3, h=2, d=0 -> 6 pixels, raw (2..4, 1..2), o_x 0..2, o_y 0..1.
- Decimation: 8x4 frame, full window, d=1 -> 8 pixels; raw x {0,2,4,6}, raw y {0,2}; o_x 0..3, o_y 0..1.
- Single shot: i_single=1, i_start, 3 frames -> only frame 1 captured; o_frame_cnt=1; o_busy=0 after its EOF.
- Mid-frame start and stop: start asserted during frame 1, stop asserted during frame 2 -> frame 1 ignored; frame 2 captured fully; IDLE afterwards; simultaneous start+stop in IDLE leaves o_busy=0.
- Async reset mid-line: assert rst during ACTIVE -> all outputs 0 immediately, no o_eof; next start plus full frame behaves as in the full-window scenario.

Source files
------------

// File: rtl/pixel_window_capture.sv
// Sensor capture front end: crops a window out of the raw FVAL/LVAL stream, decimates by 2^d
// and emits window-relative X/Y with SOF/EOF markers. Two-cycle latency, no backpressure.
module pixel_window_capture #(
  parameter int DATA_W  = 12,
  parameter int X_W     = 16,
  parameter int Y_W     = 16,
  parameter int FRAME_W = 32,
  parameter int DEC_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_fval,
  input  logic               i_lval,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_single,
  input  logic [X_W-1:0]     i_win_x0,
  input  logic [Y_W-1:0]     i_win_y0,
  input  logic [X_W-1:0]     i_win_w,
  input  logic [Y_W-1:0]     i_win_h,
  input  logic [DEC_W-1:0]   i_decim,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_dval,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic               o_sof,
  output logic               o_eof,
  output logic [FRAME_W-1:0] o_frame_cnt,
  output logic               o_busy
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  localparam logic [X_W-1:0]     X_ONE = 1;
  localparam logic [Y_W-1:0]     Y_ONE = 1;
  localparam logic [FRAME_W-1:0] F_ONE = 1;

  state_t state_q, state_d;

  logic [DATA_W-1:0] data_s1_q;
  logic              fval_s1_q, lval_s1_q, fval_prev_q, lval_prev_q;

  logic [X_W-1:0]    x0_q, w_q, rx_q, rx_d;
  logic [Y_W-1:0]    y0_q, h_q, ry_q, ry_d;
  logic [DEC_W-1:0]  decim_q;
  logic              single_q, single_d;
  logic              stop_q, stop_d;
  logic              sof_pend_q, sof_pend_d;

  logic [DATA_W-1:0]  data_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic               dval_q, sof_q, eof_q;
  logic [FRAME_W-1:0] frame_cnt_q;

  logic fval_rise, fval_fall, lval_fall;
  logic sof_evt, eof_evt, emit;
  logic [X_W-1:0] dx, mask_x;
  logic [Y_W-1:0] dy, mask_y;
  logic [X_W:0]   x_end;
  logic [Y_W:0]   y_end;
  logic in_x, in_y;

  assign fval_rise = fval_s1_q & ~fval_prev_q;
  assign fval_fall = ~fval_s1_q & fval_prev_q;
  assign lval_fall = ~lval_s1_q & lval_prev_q;

  // Window end is one bit wider so x0+w never wraps back into range.
  assign dx     = rx_q - x0_q;
  assign dy     = ry_q - y0_q;
  assign x_end  = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end  = {1'b0, y0_q} + {1'b0, h_q};
  assign mask_x = ~({X_W{1'b1}} << decim_q);
  assign mask_y = ~({Y_W{1'b1}} << decim_q);
  assign in_x   = (rx_q >= x0_q) && ({1'b0, rx_q} < x_end);
  assign in_y   = (ry_q >= y0_q) && ({1'b0, ry_q} < y_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (i_start && !i_stop) state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (i_stop)         state_d = IDLE;
        else if (fval_rise) state_d = ACTIVE;
      end
      ACTIVE:   if (fval_fall) state_d = (single_q || stop_q || i_stop) ? IDLE : WAIT_SOF;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    sof_evt    = (state_q == WAIT_SOF) && fval_rise && !i_stop;
    eof_evt    = (state_q == ACTIVE) && fval_fall;
    emit       = (state_q == ACTIVE) && lval_s1_q && in_x && in_y &&
                 ((dx & mask_x) == '0) && ((dy & mask_y) == '0);
    single_d   = (state_q == IDLE && i_start && !i_stop) ? i_single : single_q;
    stop_d     = eof_evt ? 1'b0 : ((state_q == ACTIVE && i_stop) ? 1'b1 : stop_q);
    sof_pend_d = sof_evt ? 1'b1 : (emit ? 1'b0 : sof_pend_q);
    rx_d       = rx_q;
    ry_d       = ry_q;
    if (sof_evt) begin
      rx_d = '0;
      ry_d = '0;
    end else if (state_q == ACTIVE) begin
      rx_d = !lval_s1_q ? '0 : ((rx_q == '1) ? rx_q : rx_q + X_ONE);
      if (lval_fall && ry_q != '1) ry_d = ry_q + Y_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_s1_q   <= '0;
      fval_s1_q   <= 1'b0;
      lval_s1_q   <= 1'b0;
      fval_prev_q <= 1'b0;
      lval_prev_q <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      decim_q     <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      single_q    <= 1'b0;
      stop_q      <= 1'b0;
      sof_pend_q  <= 1'b0;
      data_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dval_q      <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      data_s1_q   <= i_data;
      fval_s1_q   <= i_fval;
      lval_s1_q   <= i_lval;
      fval_prev_q <= fval_s1_q;
      lval_prev_q <= lval_s1_q;
      // Shadow configuration is frozen for the whole frame.
      if (sof_evt) begin
        x0_q    <= i_win_x0;
        y0_q    <= i_win_y0;
        w_q     <= i_win_w;
        h_q     <= i_win_h;
        decim_q <= i_decim;
      end
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      single_q   <= single_d;
      stop_q     <= stop_d;
      sof_pend_q <= sof_pend_d;
      dval_q     <= emit;
      sof_q      <= emit && sof_pend_q;
      eof_q      <= eof_evt;
      if (emit) begin
        data_q <= data_s1_q;
        x_q    <= dx >> decim_q;
        y_q    <= dy >> decim_q;
      end
      if (eof_evt) frame_cnt_q <= frame_cnt_q + F_ONE;
    end
  end

  assign o_data      = data_q;
  assign o_dval      = dval_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_busy      = (state_q != IDLE);

endmodule
